// File: rtl/chu_video_layer_mixer.sv
// N-layer video compositor: per-layer key/enable/blend over a background, 2-cycle fixed latency.
// Optional macro MIXER_BLEND_EN enables the 50% blend path; without it every hit layer overwrites.
module chu_video_layer_mixer #(
  parameter int            NL        = 4,
  parameter int            CD        = 12,
  parameter logic [CD-1:0] KEY_COLOR = '0,
  parameter logic [CD-1:0] BG_COLOR  = CD'(12'h008)
) (
  input  logic             clk_sys,
  input  logic             reset_sys,
  input  logic             cs,
  input  logic             write,
  input  logic [13:0]      addr,
  input  logic [31:0]      wr_data,
  output logic [31:0]      rd_data,
  input  logic [NL*CD-1:0] si_rgb,
  input  logic             si_valid,
  input  logic             si_frame_start,
  output logic [CD:0]      so_data,
  output logic             so_valid
);
  localparam int         CW     = CD / 3;
  localparam logic [13:0] A_BG   = 14'(NL);
  localparam logic [13:0] A_CTRL = 14'(NL + 1);

  logic [CD-1:0] key_sh_q [NL];
  logic [CD-1:0] key_sh_d [NL];
  logic [CD-1:0] key_act_q [NL];
  logic [CD-1:0] key_act_d [NL];
  logic [NL-1:0] en_sh_q, en_sh_d, en_act_q, en_act_d;
  logic [NL-1:0] blend_sh_q, blend_sh_d, blend_act_q, blend_act_d;
  logic [CD-1:0] bg_sh_q, bg_sh_d, bg_act_q, bg_act_d;
  logic          sync_q, sync_d, pending_q, pending_d;
  logic          sh_wr, fs_in, wr_en;
  logic          unused_wr_bits;

  logic [NL*CD-1:0] rgb_p1_q;
  logic [NL-1:0]    hit_p1_q, hit_p1_d, blend_p1_q;
  logic [CD-1:0]    bg_p1_q;
  logic             vld_p1_q, fs_p1_q;
  logic [CD:0]      so_data_q, so_data_d;
  logic             so_valid_q;

  assign unused_wr_bits = ^wr_data;
  assign wr_en = cs && write;
  assign fs_in = si_valid && si_frame_start;

  function automatic logic [CD-1:0] avg(input logic [CD-1:0] a, input logic [CD-1:0] b);
    logic [CD-1:0] r;
    logic [CW:0]   s;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      s = {1'b0, a[c*CW +: CW]} + {1'b0, b[c*CW +: CW]};
      r[c*CW +: CW] = s[CW:1];
    end
    return r;
  endfunction

  // Shadow writes, commit to active registers and pending tracking
  always_comb begin
    key_sh_d   = key_sh_q;
    en_sh_d    = en_sh_q;
    blend_sh_d = blend_sh_q;
    bg_sh_d    = bg_sh_q;
    sync_d     = sync_q;
    sh_wr      = 1'b0;
    for (int k = 0; k < NL; k++) begin
      if (wr_en && addr == 14'(k)) begin
        key_sh_d[k] = wr_data[CD-1:0];
        en_sh_d[k]  = wr_data[16];
`ifdef MIXER_BLEND_EN
        blend_sh_d[k] = wr_data[17];
`endif
        sh_wr = 1'b1;
      end
    end
    if (wr_en && addr == A_BG) begin
      bg_sh_d = wr_data[CD-1:0];
      sh_wr   = 1'b1;
    end
    if (wr_en && addr == A_CTRL) sync_d = wr_data[0];

    // Frame-start commit takes next-shadow so a coincident write lands on this edge
    if (!sync_q) begin
      key_act_d = key_sh_q; en_act_d = en_sh_q; blend_act_d = blend_sh_q; bg_act_d = bg_sh_q;
    end else if (fs_in) begin
      key_act_d = key_sh_d; en_act_d = en_sh_d; blend_act_d = blend_sh_d; bg_act_d = bg_sh_d;
    end else begin
      key_act_d = key_act_q; en_act_d = en_act_q; blend_act_d = blend_act_q; bg_act_d = bg_act_q;
    end

    if (!sync_q || fs_in) pending_d = 1'b0;
    else if (sh_wr)       pending_d = 1'b1;
    else                  pending_d = pending_q;
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NL; k++) begin
      if (addr == 14'(k)) begin
        rd_data[CD-1:0] = key_sh_q[k];
        rd_data[16]     = en_sh_q[k];
        rd_data[17]     = blend_sh_q[k];
      end
    end
    if (addr == A_BG)   rd_data[CD-1:0] = bg_sh_q;
    if (addr == A_CTRL) rd_data[1:0]    = {pending_q, sync_q};
  end

  // S1: hits are taken against the config being committed on this edge
  always_comb begin
    for (int k = 0; k < NL; k++)
      hit_p1_d[k] = en_act_d[k] && (si_rgb[k*CD +: CD] != key_act_d[k]);
  end

  // S2: bottom-to-top fold so the highest hit layer is applied last
  always_comb begin
    logic [CD-1:0] acc;
    acc = bg_p1_q;
    for (int k = 0; k < NL; k++) begin
      if (hit_p1_q[k]) begin
`ifdef MIXER_BLEND_EN
        acc = blend_p1_q[k] ? avg(acc, rgb_p1_q[k*CD +: CD]) : rgb_p1_q[k*CD +: CD];
`else
        acc = rgb_p1_q[k*CD +: CD];
`endif
      end
    end
    so_data_d = {acc, fs_p1_q};
  end

  always_ff @(posedge clk_sys) begin
    if (reset_sys) begin
      key_sh_q    <= '{default: KEY_COLOR};
      key_act_q   <= '{default: KEY_COLOR};
      en_sh_q     <= '1;
      en_act_q    <= '1;
      blend_sh_q  <= '0;
      blend_act_q <= '0;
      bg_sh_q     <= BG_COLOR;
      bg_act_q    <= BG_COLOR;
      sync_q      <= 1'b0;
      pending_q   <= 1'b0;
      rgb_p1_q    <= '0;
      hit_p1_q    <= '0;
      blend_p1_q  <= '0;
      bg_p1_q     <= '0;
      vld_p1_q    <= 1'b0;
      fs_p1_q     <= 1'b0;
      so_data_q   <= '0;
      so_valid_q  <= 1'b0;
    end else begin
      key_sh_q    <= key_sh_d;
      key_act_q   <= key_act_d;
      en_sh_q     <= en_sh_d;
      en_act_q    <= en_act_d;
      blend_sh_q  <= blend_sh_d;
      blend_act_q <= blend_act_d;
      bg_sh_q     <= bg_sh_d;
      bg_act_q    <= bg_act_d;
      sync_q      <= sync_d;
      pending_q   <= pending_d;
      rgb_p1_q    <= si_rgb;
      hit_p1_q    <= hit_p1_d;
      blend_p1_q  <= blend_act_d;
      bg_p1_q     <= bg_act_d;
      vld_p1_q    <= si_valid;
      fs_p1_q     <= fs_in;
      so_data_q   <= so_data_d;
      so_valid_q  <= vld_p1_q;
    end
  end

  assign so_data  = so_data_q;
  assign so_valid = so_valid_q;
endmodule

// File: tb/tb_chu_video_layer_mixer.sv
// Directed bench for chu_video_layer_mixer (NL=4, CD=12): table vectors plus register/commit sequences.
module tb_chu_video_layer_mixer;
  logic        clk = 1'b0;
  logic        reset_sys, cs, write;
  logic [13:0] addr;
  logic [31:0] wr_data, rd_data;
  logic [47:0] si_rgb;
  logic        si_valid, si_frame_start;
  logic [12:0] so_data;
  logic        so_valid;

  int errors = 0;
  int checks = 0;

`ifdef MIXER_BLEND_EN
  localparam logic [11:0] EXP_BL1 = 12'h777;
  localparam logic [11:0] EXP_BL2 = 12'h77B;
  localparam logic [31:0] RD_L3B  = 32'h0003_0000;
`else
  localparam logic [11:0] EXP_BL1 = 12'hFFF;
  localparam logic [11:0] EXP_BL2 = 12'hFFF;
  localparam logic [31:0] RD_L3B  = 32'h0001_0000;
`endif

  chu_video_layer_mixer dut (
    .clk_sys(clk), .reset_sys(reset_sys), .cs(cs), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .si_rgb(si_rgb), .si_valid(si_valid),
    .si_frame_start(si_frame_start), .so_data(so_data), .so_valid(so_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] rgb;
    logic        fs;
    logic [11:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    tick();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [13:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rd_data, exp);
  endtask

  initial begin
    vec_t vt[8];
    logic pv[6];
    logic pf[6];
    vt[0] = '{48'h000_000_000_000, 1'b0, 12'h008};
    vt[1] = '{48'h0F0_000_F00_000, 1'b0, 12'h0F0};
    vt[2] = '{48'h000_000_F00_000, 1'b1, 12'hF00};
    vt[3] = '{48'h000_000_000_123, 1'b0, 12'h123};
    vt[4] = '{48'h000_333_222_111, 1'b0, 12'h333};
    vt[5] = '{48'h000_001_000_000, 1'b1, 12'h001};
    vt[6] = '{48'hABC_000_000_FFF, 1'b0, 12'hABC};
    vt[7] = '{48'h000_000_456_000, 1'b0, 12'h456};
    pv = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    pf = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    reset_sys = 1'b1; cs = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    si_rgb = '0; si_valid = 1'b0; si_frame_start = 1'b0;
    tick(); tick(); tick();
    chk("reset_so_data", 32'(so_data), 32'h0);
    chk("reset_so_valid", 32'(so_valid), 32'h0);
    rdchk("reset_layer0", 14'd0, 32'h0001_0000);
    rdchk("reset_bg", 14'd4, 32'h0000_0008);
    rdchk("reset_ctrl", 14'd5, 32'h0);
    rdchk("out_of_range_rd", 14'd6, 32'h0);

    reset_sys = 1'b0;
    si_valid = 1'b1;
    tick();
    chk("post_reset_valid0", 32'(so_valid), 32'h0);

    for (int i = 0; i < 8; i++) begin
      si_rgb = vt[i].rgb; si_frame_start = vt[i].fs;
      tick();
      si_frame_start = 1'b0;
      tick();
      chk($sformatf("vec%0d_data", i), 32'(so_data), 32'({vt[i].exp, vt[i].fs}));
      chk($sformatf("vec%0d_valid", i), 32'(so_valid), 32'h1);
    end

    // Out-of-range write must not disturb any register
    wr(14'd9, 32'h0000_0FFF);
    rdchk("oor_wr_bg", 14'd4, 32'h0000_0008);

    // Disable top layer: old result until the pixel after the commit
    si_rgb = 48'h0F0_000_F00_000;
    tick(); tick();
    wr(14'd3, 32'h0);
    tick();
    chk("disable_l3_old", 32'(so_data), 32'({12'h0F0, 1'b0}));
    tick();
    chk("disable_l3_new", 32'(so_data), 32'({12'hF00, 1'b0}));
    rdchk("rd_l3_disabled", 14'd3, 32'h0);
    wr(14'd3, 32'h0001_0000);

    // Blend over opaque layer, then over background
    wr(14'd1, 32'h0001_0123);
    wr(14'd3, 32'h0003_0000);
    si_rgb = 48'hFFF_000_000_000;
    tick(); tick(); tick();
    chk("blend_over_l1", 32'(so_data), 32'({EXP_BL1, 1'b0}));
    rdchk("rd_l3_blend", 14'd3, RD_L3B);
    wr(14'd1, 32'h0001_0000);
    tick(); tick(); tick();
    chk("blend_over_bg", 32'(so_data), 32'({EXP_BL2, 1'b0}));
    wr(14'd3, 32'h0001_0000);

    // Deferred commit at frame start
    si_rgb = 48'h000_000_F00_000;
    wr(14'd5, 32'h1);
    wr(14'd1, 32'h0001_0F00);
    rdchk("sync_pending_set", 14'd5, 32'h3);
    rdchk("sync_shadow_rd", 14'd1, 32'h0001_0F00);
    tick(); tick(); tick();
    chk("sync_hold_old", 32'(so_data), 32'({12'hF00, 1'b0}));
    si_frame_start = 1'b1;
    tick();
    si_frame_start = 1'b0;
    chk("sync_pre_fs_pixel", 32'(so_data), 32'({12'hF00, 1'b0}));
    rdchk("sync_pending_clr", 14'd5, 32'h1);
    tick();
    chk("sync_fs_pixel_keyed", 32'(so_data), 32'({12'h008, 1'b1}));

    // Write coincident with frame start commits on the same edge
    cs = 1'b1; write = 1'b1; addr = 14'd1; wr_data = 32'h0001_0000; si_frame_start = 1'b1;
    tick();
    cs = 1'b0; write = 1'b0; si_frame_start = 1'b0;
    rdchk("same_cycle_no_pending", 14'd5, 32'h1);
    tick();
    chk("same_cycle_commit", 32'(so_data), 32'({12'hF00, 1'b1}));
    wr(14'd5, 32'h0);

    // Valid gaps track through the pipeline with exact 2-cycle latency
    for (int i = 0; i < 6; i++) begin
      si_valid = pv[i]; si_frame_start = pf[i];
      tick();
      if (i >= 1) begin
        chk($sformatf("gap%0d_valid", i), 32'(so_valid), 32'(pv[i-1]));
        chk($sformatf("gap%0d_fs", i), 32'(so_data[0]), 32'(pv[i-1] & pf[i-1]));
      end
    end
    si_frame_start = 1'b0;

    // Reset mid-stream with a pending update
    si_valid = 1'b1;
    wr(14'd5, 32'h1);
    wr(14'd2, 32'h0);
    rdchk("mid_pending", 14'd5, 32'h3);
    reset_sys = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(so_valid), 32'h0);
    chk("mid_rst_data", 32'(so_data), 32'h0);
    rdchk("mid_rst_ctrl", 14'd5, 32'h0);
    rdchk("mid_rst_l2", 14'd2, 32'h0001_0000);
    rdchk("mid_rst_l1", 14'd1, 32'h0001_0000);
    reset_sys = 1'b0;
    tick();
    chk("mid_rel_valid0", 32'(so_valid), 32'h0);
    tick();
    chk("mid_rel_valid1", 32'(so_valid), 32'h1);
    chk("mid_rel_data", 32'(so_data), 32'({12'hF00, 1'b0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
